// File: rtl/path_checker.sv
// path_checker: snoops the maze load of a solver and checks the path it
// later emits. Reports a one-cycle done pulse with pass, the first error
// code found and the number of path cells received.
//
// Handshake: a bit is taken whenever in_valid = 1; a path is a run of
// consecutive cycles with path_valid = 1 that ends on the first cycle with
// path_valid = 0; there is no back-pressure, and every input is sampled on
// the rising clock edge.
module path_checker #(
  parameter int DIM     = 15,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 13,
  parameter int GOAL_Y  = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       maze,
  input  logic       path_valid,
  input  logic       maze_not_valid,
  input  logic [3:0] path_x,
  input  logic [3:0] path_y,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_code,
  output logic [7:0] path_len,
  output logic [2:0] dbg_state
);

  localparam int CELLS = DIM * DIM;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [2:0] E_BAD_START = 3'd1;
  localparam logic [2:0] E_NOT_ADJ   = 3'd2;
  localparam logic [2:0] E_WALL      = 3'd3;
  localparam logic [2:0] E_BAD_END   = 3'd4;
  localparam logic [2:0] E_TOO_LONG  = 3'd5;
  localparam logic [2:0] E_NO_PATH   = 3'd6;
  localparam logic [2:0] E_PROTOCOL  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CELLS-1:0]  maze_q, maze_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        prev_x_q, prev_x_d;
  logic [3:0]        prev_y_q, prev_y_d;
  logic              from_start_q, from_start_d;

  logic              in_range, is_wall, at_start, at_goal, adj, end_ok, too_long;
  logic [IW-1:0]     cell_idx;
  logic [7:0]        len_inc;
  logic [2:0]        first_err, step_err, cyc_err;

  // Evaluate the incoming coordinate against the stored maze and previous cell.
  always_comb begin
    in_range = (int'(path_x) < DIM) && (int'(path_y) < DIM);
    cell_idx = IW'(int'(path_x) * DIM + int'(path_y));
    is_wall  = 1'b1;
    if (in_range) is_wall = maze_q[cell_idx];
    at_start = (path_x == 4'(START_X)) && (path_y == 4'(START_Y));
    at_goal  = (path_x == 4'(GOAL_X))  && (path_y == 4'(GOAL_Y));
    // Five-bit compares so that 15 -> 0 does not look like a unit step.
    adj = ((path_x == prev_x_q) &&
           (({1'b0, path_y} == {1'b0, prev_y_q} + 5'd1) ||
            ({1'b0, prev_y_q} == {1'b0, path_y} + 5'd1))) ||
          ((path_y == prev_y_q) &&
           (({1'b0, path_x} == {1'b0, prev_x_q} + 5'd1) ||
            ({1'b0, prev_x_q} == {1'b0, path_x} + 5'd1)));
    len_inc  = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
    too_long = int'(len_inc) > CELLS;
    // The last cell must be the endpoint opposite the one the path began at.
    end_ok = from_start_q ? ((prev_x_q == 4'(GOAL_X))  && (prev_y_q == 4'(GOAL_Y)))
                          : ((prev_x_q == 4'(START_X)) && (prev_y_q == 4'(START_Y)));
    // Lowest code wins when one coordinate breaks several rules.
    first_err = 3'd0;
    if (!(at_start || at_goal)) first_err = E_BAD_START;
    else if (is_wall)           first_err = E_WALL;
    else if (too_long)          first_err = E_TOO_LONG;
    step_err = 3'd0;
    if (!adj)                   step_err = E_NOT_ADJ;
    else if (is_wall)           step_err = E_WALL;
    else if (too_long)          step_err = E_TOO_LONG;
  end

  // Next-state and datapath updates for the load / wait / check / report flow.
  always_comb begin
    state_d      = state_q;
    maze_d       = maze_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    len_d        = len_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    from_start_d = from_start_q;
    cyc_err      = 3'd0;
    case (state_q)
      S_IDLE: begin
        // The strobe that leaves IDLE already carries bit 0 of the frame.
        if (in_valid) begin
          maze_d[0] = maze;
          cnt_d     = IW'(1);
          pass_d    = 1'b0;
          err_d     = 3'd0;
          len_d     = 8'd0;
          state_d   = (CELLS == 1) ? S_WAIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          maze_d[cnt_q] = maze;
          cnt_d         = cnt_q + IW'(1);
          if (cnt_q == IW'(CELLS - 1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (path_valid) begin
          len_d        = len_inc;
          prev_x_d     = path_x;
          prev_y_d     = path_y;
          from_start_d = at_start;
          cyc_err      = first_err;
          state_d      = S_CHECK;
        end else if (maze_not_valid) begin
          cyc_err = E_NO_PATH;
          state_d = S_REPORT;
        end
        if (in_valid) begin
          if (cyc_err == 3'd0) cyc_err = E_PROTOCOL;
          state_d = S_REPORT;
        end
      end
      S_CHECK: begin
        if (path_valid) begin
          len_d    = len_inc;
          prev_x_d = path_x;
          prev_y_d = path_y;
          cyc_err  = step_err;
        end else begin
          if (!end_ok) cyc_err = E_BAD_END;
          state_d = S_REPORT;
        end
        if (in_valid) begin
          if (cyc_err == 3'd0) cyc_err = E_PROTOCOL;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if ((err_q == 3'd0) && (cyc_err != 3'd0)) err_d = cyc_err;
    if (state_d == S_REPORT) begin
      done_d = 1'b1;
      pass_d = (err_d == 3'd0);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      maze_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 3'd0;
      len_q        <= 8'd0;
      prev_x_q     <= 4'd0;
      prev_y_q     <= 4'd0;
      from_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      maze_q       <= maze_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      len_q        <= len_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      from_start_q <= from_start_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_q;
  assign path_len  = len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_path_checker.sv
// tb_path_checker: directed and randomized checks of path_checker against a
// rule-level reference model of the path verdict.
module tb_path_checker;

  localparam int DIM   = 15;
  localparam int CELLS = DIM * DIM;
  localparam int SX = 1, SY = 1, GX = 13, GY = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       maze = 1'b0;
  logic       path_valid = 1'b0;
  logic       maze_not_valid = 1'b0;
  logic [3:0] path_x = 4'd0;
  logic [3:0] path_y = 4'd0;
  logic       done, pass;
  logic [2:0] err_code;
  logic [7:0] path_len;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  bit  mz [DIM][DIM];
  int  px_q[$];
  int  py_q[$];
  logic [11:0] exp_q[$];   // {pass, err_code, path_len}

  path_checker #(.DIM(DIM), .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .maze(maze),
    .path_valid(path_valid), .maze_not_valid(maze_not_valid),
    .path_x(path_x), .path_y(path_y), .done(done), .pass(pass),
    .err_code(err_code), .path_len(path_len), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: apply the path rules to the whole coordinate list.
  function automatic logic [11:0] model(input bit proto);
    int err = 0;
    int n = px_q.size();
    int len;
    for (int i = 0; i < n; i++) begin
      int code = 0;
      int x = px_q[i];
      int y = py_q[i];
      bit wall = !(x < DIM && y < DIM) || mz[x % DIM][y % DIM];
      if (i == 0) begin
        if (!((x == SX && y == SY) || (x == GX && y == GY))) code = 1;
        else if (wall) code = 3;
      end else begin
        int dx = x - px_q[i-1];
        int dy = y - py_q[i-1];
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (dx + dy != 1) code = 2;
        else if (wall) code = 3;
      end
      if (code == 0 && i + 1 > CELLS) code = 5;
      if (err == 0) err = code;
    end
    if (proto) begin
      if (err == 0) err = 7;
    end else if (err == 0) begin
      bit began_at_start = (px_q[0] == SX && py_q[0] == SY);
      int ex = began_at_start ? GX : SX;
      int ey = began_at_start ? GY : SY;
      if (px_q[n-1] != ex || py_q[n-1] != ey) err = 4;
    end
    len = (n > 255) ? 255 : n;
    return {(err == 0), 3'(err), 8'(len)};
  endfunction

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; path_valid = 1'b0; maze_not_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic open_maze();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mz[r][c] = (r == 0 || c == 0 || r == DIM-1 || c == DIM-1);
  endtask

  task automatic random_maze();
    open_maze();
    for (int r = 1; r < DIM-1; r++)
      for (int c = 1; c < DIM-1; c++)
        mz[r][c] = ($urandom_range(0, 5) == 0);
    mz[SX][SY] = 1'b0;
    mz[GX][GY] = 1'b0;
  endtask

  task automatic load_maze();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(negedge clk); in_valid = 1'b0;
        end
        @(negedge clk); in_valid = 1'b1; maze = mz[r][c];
      end
    @(negedge clk); in_valid = 1'b0; maze = 1'b0;
    check("load_err_clear", err_code, 0);
    check("load_len_clear", path_len, 0);
    check("load_pass_clear", pass, 0);
  endtask

  task automatic start_at(input int x, input int y);
    px_q.delete(); py_q.delete();
    px_q.push_back(x); py_q.push_back(y);
  endtask

  task automatic add_leg(input int tx, input int ty);
    int x = px_q[$];
    int y = py_q[$];
    while (x != tx) begin x += (tx > x) ? 1 : -1; px_q.push_back(x); py_q.push_back(y); end
    while (y != ty) begin y += (ty > y) ? 1 : -1; px_q.push_back(x); py_q.push_back(y); end
  endtask

  // Wait for the verdict pulse after the triggering cycle and score it.
  task automatic finish_check(input string tag);
    logic [11:0] exp = exp_q.pop_front();
    int lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      path_valid = 1'b0; in_valid = 1'b0; maze_not_valid = 1'b0;
      if (done) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, 1);
    if (lat != 0) begin
      check({tag, "_pass"}, pass, exp[11]);
      check({tag, "_err"}, err_code, exp[10:8]);
      check({tag, "_len"}, path_len, exp[7:0]);
      @(negedge clk);
      check({tag, "_done_width"}, done, 0);
      check({tag, "_err_held"}, err_code, exp[10:8]);
    end
  endtask

  task automatic drive_path(input string tag, input bit proto);
    for (int i = 0; i < px_q.size(); i++) begin
      @(negedge clk);
      path_valid = 1'b1; path_x = 4'(px_q[i]); path_y = 4'(py_q[i]);
      if (proto && i == px_q.size() - 1) in_valid = 1'b1;
    end
    if (!proto) begin
      @(negedge clk); path_valid = 1'b0;
    end
    finish_check(tag);
  endtask

  // Stimulus and final report
  initial begin
    do_reset();
    @(negedge clk);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_code, 0);
    check("reset_len", path_len, 0);

    // Clean 25-cell path from the goal to the start.
    open_maze(); load_maze();
    start_at(13, 13); add_leg(13, 1); add_leg(1, 1);
    exp_q.push_back({1'b1, 3'd0, 8'd25});
    drive_path("clean", 1'b0);

    // Path strobes and no-path flags while idle must not disturb the verdict.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      path_valid = 1'b1; maze_not_valid = 1'($urandom_range(0, 1));
      path_x = 4'($urandom_range(0, 15)); path_y = 4'($urandom_range(0, 15));
    end
    @(negedge clk); path_valid = 1'b0; maze_not_valid = 1'b0;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_pass_held", pass, 1);
    check("idle_len_held", path_len, 25);

    load_maze();
    start_at(2, 2); add_leg(13, 13);
    exp_q.push_back({1'b0, 3'd1, 8'd23});
    drive_path("bad_start", 1'b0);

    load_maze();
    start_at(13, 13); px_q.push_back(12); py_q.push_back(12);
    px_q.push_back(12); py_q.push_back(13);
    px_q.push_back(12); py_q.push_back(14);
    exp_q.push_back({1'b0, 3'd2, 8'd4});
    drive_path("not_adj", 1'b0);

    mz[7][7] = 1'b1; load_maze();
    start_at(1, 1); add_leg(7, 1); add_leg(7, 13); add_leg(13, 13);
    exp_q.push_back({1'b0, 3'd3, 8'd25});
    drive_path("wall", 1'b0);
    mz[7][7] = 1'b0;

    load_maze();
    start_at(1, 1);
    exp_q.push_back({1'b0, 3'd4, 8'd1});
    drive_path("single_cell", 1'b0);

    load_maze();
    start_at(1, 1);
    for (int i = 1; i < 260; i++) begin px_q.push_back(1); py_q.push_back(1 + (i % 2)); end
    exp_q.push_back({1'b0, 3'd5, 8'd255});
    drive_path("too_long", 1'b0);

    load_maze();
    start_at(1, 1); add_leg(1, 4);
    exp_q.push_back({1'b0, 3'd7, 8'd4});
    drive_path("protocol", 1'b1);

    load_maze();
    exp_q.push_back({1'b0, 3'd6, 8'd0});
    @(negedge clk); maze_not_valid = 1'b1;
    finish_check("no_path");

    // Reset in the middle of a load, then a full clean reload.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); in_valid = 1'b1; maze = 1'b1;
    end
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b1; maze = 1'b1;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; maze = 1'b0;
    check("midload_reset_done", done, 0);
    check("midload_reset_len", path_len, 0);
    load_maze();
    start_at(1, 1); add_leg(1, 13); add_leg(13, 13);
    exp_q.push_back({1'b1, 3'd0, 8'd25});
    drive_path("after_reset", 1'b0);

    // Randomized paths scored by the model.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        open_maze(); load_maze();
        if ($urandom_range(0, 1) == 0) start_at(SX, SY); else start_at(GX, GY);
        add_leg($urandom_range(1, 13), $urandom_range(1, 13));
        if (px_q[0] == SX) add_leg(GX, GY); else add_leg(SX, SY);
        if ($urandom_range(0, 2) == 0) begin
          int j = $urandom_range(0, px_q.size() - 1);
          px_q[j] = $urandom_range(0, 15); py_q[j] = $urandom_range(0, 15);
        end
      end else begin
        int n = $urandom_range(1, 30);
        int x, y;
        random_maze(); load_maze();
        case ($urandom_range(0, 4))
          0, 1:    start_at(SX, SY);
          2:       start_at(GX, GY);
          default: start_at($urandom_range(0, 15), $urandom_range(0, 15));
        endcase
        x = px_q[0]; y = py_q[0];
        for (int s = 1; s < n; s++) begin
          case ($urandom_range(0, 9))
            0: begin x = $urandom_range(0, 15); y = $urandom_range(0, 15); end
            1, 2: x = (x + 1) % 16;
            3, 4: x = (x + 15) % 16;
            5, 6: y = (y + 1) % 16;
            default: y = (y + 15) % 16;
          endcase
          px_q.push_back(x); py_q.push_back(y);
        end
      end
      exp_q.push_back(model(1'b0));
      drive_path($sformatf("rand%0d", it), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
